ahfp_elastic_pipeline: RTL and testbench

Parametrised successor to the fixed 32-bit, fixed-depth delay line used around the AHFP arithmetic units.
- Generalised width and depth.
- Per-stage valid tracking with valid/ready handshakes at both ends.
- Bubble-collapsing stall propagation, synchronous flush, and an occupancy count.
- Sits between AHFP operator pipelines and downstream consumers that can apply backpressure.

---
 rtl/ahfp_pkg.sv | 17 +
 rtl/ahfp_pipe_stage.sv | 49 ++++
 rtl/ahfp_elastic_pipeline.sv | 117 +++++++++++
 tb/tb_ahfp_elastic_pipeline.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahfp_pkg.sv
// Shared constants and helpers for the AHFP elastic pipeline.
package ahfp_pkg;

   localparam int AHFP_WIDTH  = 32;
   localparam int AHFP_STAGES = 10;

   // Ceiling log2, usable in parameter expressions (returns 0 for value <= 1).
   function automatic int ahfp_clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ahfp_pipe_stage.sv
// One slot of the elastic pipeline: a valid bit plus a data register.
// The valid bit follows its source whenever the slot advances; the data
// register only loads real beats, so bubbles moving through leave it quiet.
module ahfp_pipe_stage
   import ahfp_pkg::*;
#(
   parameter int WIDTH = AHFP_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             src_v,
   input  logic [WIDTH-1:0] src_d,
   input  logic             adv,
   input  logic             flush,
   output logic             v,
   output logic [WIDTH-1:0] d
);

   logic             v_q;
   logic [WIDTH-1:0] d_q;

   // Valid bit: cleared by reset or flush, otherwise follows the source on advance.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments for all clocked state, so every stage
      // samples its neighbour's pre-edge value and the chain shifts correctly.
      if (!rst_n) begin
         v_q <= 1'b0;
      end else if (flush) begin
         v_q <= 1'b0;
      end else if (adv) begin
         v_q <= src_v;
      end
   end

   // Data register: loads only real beats; a flush leaves the contents alone.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the data register is reset too, because out_data must read zero
      // while reset is held; it is a single word per stage, not a memory array.
      if (!rst_n) begin
         d_q <= '0;
      end else if (!flush && adv && src_v) begin
         d_q <= src_d;
      end
   end

   assign v = v_q;
   assign d = d_q;

endmodule

// File: rtl/ahfp_elastic_pipeline.sv
// Elastic delay line for AHFP operator results: STAGES register slots with
// valid/ready handshakes at both ends, bubble-collapsing stalls, a synchronous
// flush and a registered occupancy count.
module ahfp_elastic_pipeline
   import ahfp_pkg::*;
#(
   parameter int WIDTH  = AHFP_WIDTH,
   parameter int STAGES = AHFP_STAGES,
   parameter int CNT_W  = ahfp_clog2(STAGES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             flush,
   output logic [CNT_W-1:0] occupancy
);

   localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(STAGES);
   localparam logic [CNT_W-1:0] OCC_ONE = CNT_W'(1);

   logic [STAGES-1:0] v;
   logic [WIDTH-1:0]  d     [STAGES];
   logic [STAGES-1:0] src_v;
   logic [WIDTH-1:0]  src_d [STAGES];
   logic [STAGES-1:0] adv;

   logic             acc_in;
   logic             cons_out;
   logic [CNT_W-1:0] occupancy_q;
   logic [CNT_W-1:0] occupancy_d;

   // Stage chain: stage 0 is fed from the input port, every other stage from its predecessor.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign src_v[k] = in_valid;
         assign src_d[k] = in_data;
      end else begin : g_body
         assign src_v[k] = v[k-1];
         assign src_d[k] = d[k-1];
      end

      ahfp_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .src_v (src_v[k]),
         .src_d (src_d[k]),
         .adv   (adv[k]),
         .flush (flush),
         .v     (v[k]),
         .d     (d[k])
      );
   end

   // Advance chain from the head backwards: an empty slot breaks the stall,
   // so only the contiguous valid run behind a stalled head stops.
   always_comb begin
      logic carry;
      // NOTE: every always_comb output gets a default before any branching,
      // so no path can leave a value unassigned and infer a latch.
      adv   = '0;
      carry = !v[STAGES-1] || out_ready;
      adv[STAGES-1] = carry;
      for (int k = STAGES - 2; k >= 0; k--) begin
         carry  = !v[k] || carry;
         adv[k] = carry;
      end
   end

   // Flush blocks both ends so no handshake completes during the flush cycle.
   assign in_ready  = adv[0] && !flush && rst_n;
   assign out_valid = v[STAGES-1] && !flush;
   assign out_data  = d[STAGES-1];

   assign acc_in   = in_valid && in_ready;
   assign cons_out = out_valid && out_ready;

   // Occupancy next state: +1 per accepted beat, -1 per consumed beat, cleared by flush.
   always_comb begin
      occupancy_d = occupancy_q;
      if (flush) begin
         occupancy_d = '0;
      end else begin
         unique case ({acc_in, cons_out})
            2'b10:   occupancy_d = occupancy_q + OCC_ONE;
            2'b01:   occupancy_d = occupancy_q - OCC_ONE;
            default: occupancy_d = occupancy_q;
         endcase
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy_q <= '0;
      end else begin
         occupancy_q <= occupancy_d;
      end
   end

   assign occupancy = occupancy_q;

   // Occupancy stays within 0..STAGES and always matches the number of valid slots.
   a_occ_max : assert property (@(posedge clk) disable iff (!rst_n)
      occupancy_q <= OCC_MAX);
   a_occ_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(occupancy_q == '0 && cons_out));
   a_occ_tracks_valid : assert property (@(posedge clk) disable iff (!rst_n)
      occupancy_q == CNT_W'($countones(v)));

endmodule

// File: tb/tb_ahfp_elastic_pipeline.sv
// Directed bench for ahfp_elastic_pipeline: a WIDTH=32/STAGES=10 instance
// for the main scenarios and a WIDTH=8/STAGES=1 instance for the single slot.
module tb_ahfp_elastic_pipeline;

   logic        clk;
   logic        rst_n;

   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        flush;
   logic [3:0]  occupancy;

   logic [7:0]  s_in_data;
   logic        s_in_valid;
   logic        s_in_ready;
   logic [7:0]  s_out_data;
   logic        s_out_valid;
   logic        s_out_ready;
   logic        s_flush;
   logic [0:0]  s_occupancy;

   int n_checks;
   int n_pass;

   ahfp_elastic_pipeline #(
      .WIDTH  (32),
      .STAGES (10)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flush     (flush),
      .occupancy (occupancy)
   );

   ahfp_elastic_pipeline #(
      .WIDTH  (8),
      .STAGES (1)
   ) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (s_in_data),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .out_data  (s_out_data),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .flush     (s_flush),
      .occupancy (s_occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end else begin
         n_pass = n_pass + 1;
      end
   endtask

   // Advance one clock edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      int cons;
      int exp_occ;

      n_checks    = 0;
      n_pass      = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b1;
      in_data     = 32'hDEAD_BEEF;
      out_ready   = 1'b1;
      flush       = 1'b0;
      s_in_valid  = 1'b0;
      s_in_data   = 8'h00;
      s_out_ready = 1'b0;
      s_flush     = 1'b0;

      // ---- reset held with input driven ----
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  out_data,       32'd0);
      check("rst_occupancy", 32'(occupancy), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      tick();
      tick();
      check("rst_hold_out_valid", 32'(out_valid), 32'd0);
      check("rst_hold_in_ready",  32'(in_ready),  32'd0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_release_in_ready", 32'(in_ready), 32'd1);
      tick();

      // ---- streaming 0x1..0x14 with out_ready=1 ----
      out_ready = 1'b1;
      for (int c = 0; c <= 30; c++) begin
         in_valid = (c < 20);
         in_data  = 32'(c + 1);
         #1;
         exp_occ = ((c < 20) ? c : 20) - ((c < 10) ? 0 : ((c < 30) ? c : 30) - 10);
         if (c < 20) check("stream_in_ready", 32'(in_ready), 32'd1);
         check("stream_out_valid", 32'(out_valid), 32'((c >= 10) && (c < 30)));
         if (c >= 10 && c < 30) check("stream_out_data", out_data, 32'(c - 9));
         check("stream_occupancy", 32'(occupancy), 32'(exp_occ));
         tick();
      end

      // ---- backpressure: fill with 0xA0..0xA9 ----
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = 32'hA0 + 32'(c);
         #1;
         check("bp_fill_in_ready", 32'(in_ready), 32'd1);
         tick();
      end
      in_valid = 1'b1;
      in_data  = 32'hAA;
      #1;
      check("bp_full_in_ready",  32'(in_ready),  32'd0);
      check("bp_full_occupancy", 32'(occupancy), 32'd10);
      check("bp_full_out_valid", 32'(out_valid), 32'd1);
      check("bp_full_out_data",  out_data,       32'hA0);
      tick();
      out_ready = 1'b1;
      #1;
      check("bp_pass_in_ready", 32'(in_ready), 32'd1);
      check("bp_pass_out_data", out_data,      32'hA0);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("bp_after_occupancy", 32'(occupancy), 32'd10);
      check("bp_after_out_data",  out_data,       32'hA1);
      tick();
      for (int i = 0; i < 10; i++) begin
         out_ready = 1'b1;
         #1;
         check("bp_drain_out_valid", 32'(out_valid), 32'd1);
         check("bp_drain_out_data",  out_data,       32'hA1 + 32'(i));
         tick();
      end
      #1;
      check("bp_empty_occupancy", 32'(occupancy), 32'd0);
      check("bp_empty_out_valid", 32'(out_valid), 32'd0);

      // ---- bubble collapse: 0x5 stalls at head, 0x6 slides up to stage 8 ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h5;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      #1;
      check("bubble_head_valid", 32'(out_valid), 32'd1);
      check("bubble_head_data",  out_data,       32'h5);
      in_valid = 1'b1;
      in_data  = 32'h6;
      #1;
      check("bubble_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      for (int c = 11; c < 19; c++) tick();
      check("bubble_occupancy", 32'(occupancy), 32'd2);
      check("bubble_hold_data", out_data,       32'h5);
      out_ready = 1'b1;
      tick();
      check("bubble_next_valid", 32'(out_valid), 32'd1);
      check("bubble_next_data",  out_data,       32'h6);
      tick();
      check("bubble_empty_valid", 32'(out_valid), 32'd0);
      check("bubble_empty_occ",   32'(occupancy), 32'd0);

      // ---- flush with 4 valid beats and 0xFF offered ----
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         in_data  = 32'hB1 + 32'(c);
         tick();
      end
      in_valid = 1'b0;
      for (int c = 4; c < 10; c++) tick();
      check("flush_pre_out_valid", 32'(out_valid), 32'd1);
      check("flush_pre_out_data",  out_data,       32'hB1);
      check("flush_pre_occupancy", 32'(occupancy), 32'd4);
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hFF;
      out_ready = 1'b1;
      #1;
      check("flush_in_ready",  32'(in_ready),  32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("flush_post_occupancy", 32'(occupancy), 32'd0);
      check("flush_post_data_held", out_data,       32'hB1);
      for (int c = 0; c < 12; c++) begin
         check("flush_no_ff_out_valid", 32'(out_valid), 32'd0);
         tick();
      end

      // ---- reset mid-stream ----
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         in_valid = 1'b1;
         in_data  = 32'hC0 + 32'(c);
         tick();
      end
      check("midrst_pre_out_valid", 32'(out_valid), 32'd1);
      check("midrst_pre_out_data",  out_data,       32'hC2);
      check("midrst_pre_occupancy", 32'(occupancy), 32'd10);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data",  out_data,       32'd0);
      check("midrst_occupancy", 32'(occupancy), 32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd0);
      tick();
      check("midrst_hold_out_valid", 32'(out_valid), 32'd0);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h77;
      #1;
      check("midrst_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("midrst_first_occupancy", 32'(occupancy), 32'd1);
      for (int c = 1; c < 10; c++) tick();
      check("midrst_first_out_valid", 32'(out_valid), 32'd1);
      check("midrst_first_out_data",  out_data,       32'h77);
      tick();
      check("midrst_drained_occ", 32'(occupancy), 32'd0);

      // ---- STAGES=1, WIDTH=8: alternating out_ready, continuous input ----
      acc  = 0;
      cons = 0;
      for (int c = 0; c < 12; c++) begin
         s_out_ready = (c % 2 == 0);
         s_in_valid  = 1'b1;
         s_in_data   = acc[7:0];
         #1;
         check("s1_in_ready",  32'(s_in_ready),  32'(c % 2 == 0));
         check("s1_out_valid", 32'(s_out_valid), 32'(c >= 1));
         if (c >= 1) check("s1_out_data", 32'(s_out_data), 32'((c - 1) / 2));
         check("s1_balance", 32'(acc), 32'(cons) + 32'(s_occupancy));
         if (s_in_valid && s_in_ready)   acc  = acc + 1;
         if (s_out_valid && s_out_ready) cons = cons + 1;
         tick();
      end
      s_in_valid  = 1'b0;
      s_out_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
